// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
// Fault codes are what the block reports alongside each response.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_ALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE = 2'd2;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents power up at NOP_WORD and are deliberately untouched by reset.
module imem_array #(
  parameter int                 DEPTH    = 256,
  parameter int                 DATA_W   = 32,
  parameter int                 IDX_W    = 8,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/inst_mem_pipe.sv
// Clocked instruction memory with valid/ready fetch handshake, programmable
// wait states and a run-time program-load port.
//
//   state | meaning
//   IDLE  | no response pending, ready for a fetch
//   WAIT  | fetch accepted, counting down wait states
//   RESP  | response valid, held until rsp_ready
module inst_mem_pipe
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                WAIT_CYC = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_inst,
  output logic [1:0]                rsp_fault,
  input  logic                      load_en,
  input  logic [idx_w(DEPTH)-1:0]   load_idx,
  input  logic [DATA_W-1:0]         load_data
);

  localparam int         IDX_W     = idx_w(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  imem_state_e       state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] cap_inst;
  logic [1:0]        cap_fault;
  logic              misaligned, out_of_range, accept;

  imem_array #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .widx  (load_idx),
    .wdata (load_data),
    .ridx  (req_addr[IDX_W+1:2]),
    .rdata (rd_data)
  );

  assign misaligned   = |req_addr[1:0];
  assign out_of_range = |(req_addr >> (IDX_W + 2));

  always_comb begin
    cap_fault = FAULT_NONE;
    if (misaligned)        cap_fault = FAULT_ALIGN;
    else if (out_of_range) cap_fault = FAULT_RANGE;
  end

  assign cap_inst  = (cap_fault == FAULT_NONE) ? rd_data : NOP_WORD;
  assign req_ready = !load_en && (state == IDLE || (state == RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (WAIT_CYC == 0) ? RESP : WAIT;
          cnt_nx   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP: begin
        // a retiring response can overlap the next accept
        if (accept) begin
          state_nx = (WAIT_CYC == 0) ? RESP : WAIT;
          cnt_nx   = WAIT_INIT;
        end else if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_inst  <= NOP_WORD;
      rsp_fault <= FAULT_NONE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        rsp_inst  <= cap_inst;
        rsp_fault <= cap_fault;
      end
    end
  end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised, clocked successor to the single-cycle instruction ROM. It holds DEPTH instruction words in a byte-addressed, word-aligned array. A side port loads the program at run time. Fetches use a valid/ready request/response handshake with a programmable number of wait states, so the pipelined CPU front end and a future cache can share the same block.

Parameters:
ADDR_W, 32, byte-address width of req_addr.
DATA_W, 32, instruction word width.
DEPTH, 256, number of words; must be a power of two, at least 2.
WAIT_CYC, 0, extra cycles between request accept and response valid; range 0..15.
NOP_WORD, 32'h0000_0000, power-up contents of every word; also returned on a fault.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  block can accept a fetch this cycle
req_addr  in  ADDR_W  byte address of the fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_inst  out  DATA_W  fetched instruction
rsp_fault  out  2  fault code: 0 ok, 1 misaligned, 2 out of range (misaligned wins if both apply)
load_en  in  1  program-load write strobe
load_idx  in  $clog2(DEPTH)  word index to write
load_data  in  DATA_W  word to write

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-low on clk/rst_n.
  - Reset values: state IDLE, wait counter 0, rsp_valid 0, rsp_inst NOP_WORD, rsp_fault 0.
  - Array contents are NOT cleared by reset. They power up at NOP_WORD.
- Address decode: IDX_W = $clog2(DEPTH); index = req_addr[IDX_W+1:2].
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: any bit of req_addr above IDX_W+1 is set.
  - On any fault, rsp_inst = NOP_WORD.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states; entered only when WAIT_CYC > 0.
  - RESP: rsp_valid = 1; rsp_inst and rsp_fault are held stable until rsp_ready.
- req_ready = !load_en && (state == IDLE || (state == RESP && rsp_ready)). The block has a single response slot; a new accept can overlap the retiring response.
- Accept happens on a cycle where req_valid && req_ready:
  - The array word and fault code are captured into the response holding register in that cycle (read-before-write).
  - Next state is WAIT with counter = WAIT_CYC-1, or RESP if WAIT_CYC == 0.
- WAIT: counter decrements each cycle; at 0 the next state is RESP.
- RESP with rsp_ready and no new accept: next state is IDLE and rsp_valid drops the following cycle.
- Latency: response valid 1+WAIT_CYC cycles after the accept edge. With WAIT_CYC = 0 and rsp_ready held high, throughput is one fetch per cycle.
- Load port:
  - load_en writes load_data to the array at the clock edge, in any state.
  - load_en has priority over fetch: req_ready is forced low that cycle.
  - A load to the index of an in-flight fetch does not alter its captured response.
- rsp_ready asserted while rsp_valid is low is ignored.
- req_valid held while req_ready is low must not be lost. The requester keeps req_addr stable until accepted; the block does not latch it early.
- Reset asserted mid-transaction drops the transaction: the next cycle is IDLE with rsp_valid 0, and no stale response ever appears.

Decomposition:
- imem_pkg holds:
  - state enum: IDLE, WAIT, RESP.
  - fault code constants: FAULT_NONE = 0, FAULT_ALIGN = 1, FAULT_RANGE = 2.
  - function computing IDX_W.
- One sub-module, imem_array:
  - DEPTH x DATA_W storage, initialised to NOP_WORD.
  - one synchronous write port and one asynchronous read port.
  - no reset.
- The handshake FSM and wait counter stay in inst_mem_pipe.

Test Plan:
- Load then fetch, WAIT_CYC=0:
  - Stimulus: load idx 5 = 32'h3401_4321, then fetch addr 32'h14.
  - Required: rsp_valid one cycle after accept, rsp_inst = 32'h3401_4321, rsp_fault = 0.
- Back-to-back throughput, WAIT_CYC=0, rsp_ready held 1:
  - Stimulus: fetch addr 0x00, 0x04, 0x08 on consecutive cycles.
  - Required: three consecutive rsp_valid cycles in order; req_ready stays 1.
- Wait states and backpressure, WAIT_CYC=3:
  - Stimulus: fetch, with rsp_ready held 0 for 4 cycles after rsp_valid rises.
  - Required: rsp_valid rises 4 cycles after the accept edge, rsp_inst stable while stalled, req_ready 0 until the cycle rsp_ready = 1.
- Faults:
  - Fetch addr 32'h16: rsp_fault = 1, rsp_inst = NOP_WORD.
  - Fetch addr 32'h400 with DEPTH=256: rsp_fault = 2.
  - Fetch addr 32'h402: rsp_fault = 1.
- Load priority and in-flight hazard, WAIT_CYC=2:
  - Stimulus: load_en asserted with req_valid; req_ready must be 0.
  - Then, after an accept of idx 7, a load to idx 7 during WAIT.
  - Required: the response returns the old word, and a refetch returns the new word.
- Reset mid-WAIT, WAIT_CYC=5:
  - Stimulus: rst_n = 0 for one cycle two cycles after accept.
  - Required: rsp_valid never rises for that fetch; state IDLE; previously loaded array words still readable.
